fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
Drains the read side of a show-ahead synchronous FIFO (data valid whenever not empty; pop with a read-enable) and packs PACK consecutive words into one wide output beat. The beat is presented on a valid/ready stream to the downstream wide datapath. A flush request emits a partial beat with a per-word keep mask.

Parameters:
WIDTH, 8, FIFO word width in bits
PACK, 4, words per output beat (>=2)
TIMEOUT, 16, idle cycles before auto-flush; used only with FIFO_RD_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO head word, valid when fifo_empty=0
fifo_rd_en  output  1  pop FIFO head this cycle
flush  input  1  request emission of a partial beat
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
out_data  output  PACK*WIDTH  packed beat; word 0 in LSBs
out_keep  output  PACK  bit i=1 means word i is valid
beat_cnt  output  16  number of beats handed off, wraps at 2^16

Behaviour:
- Reset (async assert, sync release): state=ACCUM, idx=0, out_valid=0, out_data=0, out_keep=0, beat_cnt=0. Asserting reset mid-operation discards any partial or held beat.
- States are ACCUM and HOLD.
- fifo_rd_en is combinational: fifo_rd_en = (state==ACCUM) && !fifo_empty. The block never pops an empty FIFO and never pops in HOLD.
- ACCUM, word accepted (fifo_rd_en=1):
  - fifo_data is written to slot idx, i.e. out_data[idx*WIDTH +: WIDTH], and keep[idx] is set.
  - If idx==PACK-1: go to HOLD and reset idx to 0. Otherwise idx increments.
- ACCUM, flush=1:
  - If idx>0, or a word is accepted in the same cycle, go to HOLD next cycle. That same-cycle word is included in the beat.
  - If idx==0 and no word is accepted, flush is ignored. No empty beats are ever emitted.
  - flush is level-sampled and needs no pulse shaping.
- HOLD:
  - out_valid=1, registered.
  - out_data and out_keep stay stable until the handshake.
  - Slots not filled read as zero.
  - On out_valid && out_ready: next cycle out_valid=0, out_data=0, out_keep=0, idx=0, state=ACCUM, and beat_cnt increments (wraps).
  - flush is ignored in HOLD.
- Latency: the word that completes a beat, accepted on edge N, gives out_valid=1 after edge N. If out_ready is held at 1, the handshake completes on edge N+1.
- Peak throughput: one beat per PACK+1 cycles.
- Backpressure: out_ready low holds HOLD indefinitely. The FIFO is not popped during this time, so the upstream FIFO fills.
- out_valid, out_data, out_keep and beat_cnt are all registered. fifo_rd_en is the only combinational output.

Optional Feature:
FIFO_RD_TIMEOUT_EN
- Defined:
  - An idle counter clears on reset, on any accepted word, and on leaving ACCUM.
  - It increments on each ACCUM cycle where idx>0 and no word is accepted.
  - When it reaches TIMEOUT, this acts as flush that cycle, and the partial beat goes to HOLD next cycle.
- Undefined: no counter is built, TIMEOUT is unused, and partial beats leave only via flush.

Test Plan:
1. WIDTH=8, PACK=4; push 0x11,0x22,0x33,0x44 with out_ready=1 -> one beat out_data=0x44332211, out_keep=4'b1111, beat_cnt=1; fifo_rd_en never high while fifo_empty=1.
2. Push 8 words 0x01..0x08 with out_ready=0 for 10 cycles after first beat -> out_data=0x04030201 held stable; fifo_rd_en=0 throughout HOLD; then second beat 0x08070605, beat_cnt=2.
3. Push 0xAA,0xBB, then flush=1 on an idle cycle -> out_data=0x0000BBAA, out_keep=4'b0011.
4. flush=1 with idx=0 and FIFO empty -> out_valid stays 0 and beat_cnt unchanged; flush in the same cycle as accepting 0xCC at idx=0 -> out_data=0x000000CC, out_keep=4'b0001.
5. Assert rst_n=0 with 3 words packed, then release -> out_valid=0, out_keep=0, beat_cnt=0; next 4 words form a clean beat.
6. FIFO_RD_TIMEOUT_EN, TIMEOUT=16; push one word 0x5A then hold FIFO empty -> out_valid rises after the 16th idle cycle with out_keep=4'b0001; without the macro, out_valid stays 0 for 100 cycles.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Drains a show-ahead FIFO and packs PACK words into one wide valid/ready beat.
// Define FIFO_RD_TIMEOUT_EN to auto-flush a partial beat after TIMEOUT idle cycles.
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  input  logic [WIDTH-1:0]        fifo_data,
  output logic                    fifo_rd_en,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PACK*WIDTH-1:0]   out_data,
  output logic [PACK-1:0]         out_keep,
  output logic [15:0]             beat_cnt
);

  localparam int IDXW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            last_slot;
  logic            flush_eff;
  logic            go_hold;

  assign fifo_rd_en = (state == ACCUM) && !fifo_empty;
  assign accept     = fifo_rd_en;
  assign last_slot  = (idx == IDXW'(PACK - 1));

  // A beat closes when its last slot fills, or on flush if it holds at least one word.
  assign go_hold = (state == ACCUM) &&
                   ((accept && (last_slot || flush_eff)) ||
                    (!accept && flush_eff && (idx != '0)));

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle;
  logic          timeout_hit;

  assign idle        = (state == ACCUM) && (idx != '0) && !accept;
  assign timeout_hit = idle && (idle_cnt == TW'(TIMEOUT - 1));
  assign flush_eff   = flush || timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (accept || (state != ACCUM) || go_hold) begin
      idle_cnt <= '0;
    end else if (idle) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign flush_eff = flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            out_data[idx*WIDTH +: WIDTH] <= fifo_data;
            out_keep[idx]                <= 1'b1;
          end
          if (go_hold) begin
            state     <= HOLD;
            idx       <= '0;
            out_valid <= 1'b1;
          end else if (accept) begin
            idx <= idx + 1'b1;
          end
        end
        HOLD: begin
          // Clearing data/keep here keeps unfilled slots of the next beat at zero.
          if (out_ready) begin
            state     <= ACCUM;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            beat_cnt  <= beat_cnt + 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
